// File: rtl/prf_skewed_writeback.sv
// rtl/prf_skewed_writeback.sv - skewed byte-sliced PRF writeback producer with bypass broadcast
module prf_skewed_writeback #(
  parameter int SRAM_DATA_WIDTH   = 8,
  parameter int SIZE_DATA         = 32,
  parameter int SIZE_PHYSICAL_LOG = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         resultValid_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] resultTag_i,
  input  logic [SIZE_DATA-1:0]         resultData_i,
  output logic                         bypassValid_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] bypassTag_o,
  output logic [SIZE_DATA-1:0]         bypassData_o,
  output logic                         we0_o,
  output logic                         we1_o,
  output logic                         we2_o,
  output logic                         we3_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] waddr0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] waddr1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] waddr2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] waddr3_o,
  output logic [SRAM_DATA_WIDTH-1:0]   wdata0_o,
  output logic [SRAM_DATA_WIDTH-1:0]   wdata1_o,
  output logic [SRAM_DATA_WIDTH-1:0]   wdata2_o,
  output logic [SRAM_DATA_WIDTH-1:0]   wdata3_o,
  output logic [2:0]                   inflight_o
);

  localparam int W = SRAM_DATA_WIDTH;

  if (SIZE_DATA != 4 * SRAM_DATA_WIDTH) begin : g_bad_width
    $error("prf_skewed_writeback: SIZE_DATA must equal 4*SRAM_DATA_WIDTH");
  end

  // Stage k keeps only the bytes that banks k..3 still need.
  logic [SIZE_PHYSICAL_LOG-1:0] s0_tag, s1_tag, s2_tag, s3_tag;
  logic [SIZE_DATA-1:0]         s0_data;
  logic [SIZE_DATA-W-1:0]       s1_data;
  logic [SIZE_DATA-2*W-1:0]     s2_data;
  logic [W-1:0]                 s3_data;

  // Stage valids double as the bank write enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      we0_o      <= 1'b0;
      we1_o      <= 1'b0;
      we2_o      <= 1'b0;
      we3_o      <= 1'b0;
      s0_tag     <= '0;
      s1_tag     <= '0;
      s2_tag     <= '0;
      s3_tag     <= '0;
      s0_data    <= '0;
      s1_data    <= '0;
      s2_data    <= '0;
      s3_data    <= '0;
      inflight_o <= 3'd0;
    end else begin
      we0_o <= resultValid_i;
      we1_o <= we0_o;
      we2_o <= we1_o;
      we3_o <= we2_o;
      if (resultValid_i) begin
        s0_tag  <= resultTag_i;
        s0_data <= resultData_i;
      end
      if (we0_o) begin
        s1_tag  <= s0_tag;
        s1_data <= s0_data[SIZE_DATA-1:W];
      end
      if (we1_o) begin
        s2_tag  <= s1_tag;
        s2_data <= s1_data[SIZE_DATA-W-1:W];
      end
      if (we2_o) begin
        s3_tag  <= s2_tag;
        s3_data <= s2_data[SIZE_DATA-2*W-1:W];
      end
      // Population of next-cycle valids: +1 on accept, -1 as bank 3 retires.
      inflight_o <= {2'b00, resultValid_i} + {2'b00, we0_o}
                  + {2'b00, we1_o} + {2'b00, we2_o};
    end
  end

  assign bypassValid_o = we0_o;
  assign bypassTag_o   = s0_tag;
  assign bypassData_o  = s0_data;

  assign waddr0_o = s0_tag;
  assign waddr1_o = s1_tag;
  assign waddr2_o = s2_tag;
  assign waddr3_o = s3_tag;

  assign wdata0_o = s0_data[W-1:0];
  assign wdata1_o = s1_data[W-1:0];
  assign wdata2_o = s2_data[W-1:0];
  assign wdata3_o = s3_data;

  a_inflight_max: assert property (@(posedge clk) disable iff (reset) inflight_o <= 3'd4);
  a_bypass_we0:   assert property (@(posedge clk) disable iff (reset) bypassValid_o == we0_o);

endmodule
